// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Producer side of the integer ALU operand interface. Takes raw RV32I words
// from fetch, decodes OP / OP-IMM, reads the register file in the accept
// cycle and presents a registered operand bundle to the ALU. A one-entry
// skid buffer behind the output register absorbs one bundle of back-pressure,
// so inst_ready can be a pure register output.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   inst_valid/inst_ready    fetch handshake; inst_ready is registered
//   inst                     raw instruction word
//   rs1_addr/rs2_addr        combinational register file read addresses
//   rs1_data/rs2_data        register file read data, same cycle
//   alu_valid/alu_ready      ALU handshake
//   op1, op2, funct3, funct7, imm_type, immediate, rd, illegal
//                            decoded bundle, stable while stalled
//   issue_cnt, stall_cnt     only with ALU_ISSUE_PERF_EN defined
//
// Optional feature macro: ALU_ISSUE_PERF_EN (transfer and stall counters).
//
// state | meaning
// EMPTY | no bundle held, output invalid
// ONE   | output register holds a bundle, skid empty
// FULL  | output and skid both hold bundles, inst_ready low
module alu_issue_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inst_valid,
   output logic            inst_ready,
   input  logic [31:0]     inst,
   output logic [RA_W-1:0] rs1_addr,
   output logic [RA_W-1:0] rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            alu_valid,
   input  logic            alu_ready,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic            imm_type,
   output logic [11:0]     immediate,
   output logic [RA_W-1:0] rd,
   output logic            illegal
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]     issue_cnt,
   output logic [31:0]     stall_cnt
`endif
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic            imm_type;
      logic [11:0]     immediate;
      logic [RA_W-1:0] rd;
      logic            illegal;
   } bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t  state_q, state_d;
   bundle_t dec, out_q, skid_q;
   logic    ready_q;
   logic    accept, xfer, out_v;
   logic    load_out, load_skid, skid_to_out;

   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic [XLEN-1:0] src1, src2;

   assign rs1_addr = inst[15 +: RA_W];
   assign rs2_addr = inst[20 +: RA_W];
   assign opc      = inst[6:0];
   assign f3       = inst[14:12];
   assign f7       = inst[31:25];

   // x0 reads as zero no matter what the register file returns
   assign src1 = (rs1_addr == '0) ? '0 : rs1_data;
   assign src2 = (rs2_addr == '0) ? '0 : rs2_data;

   always_comb begin
      dec = '0;
      if (opc == OPC_OP) begin
         dec.op1     = src1;
         dec.op2     = src2;
         dec.funct3  = f3;
         dec.funct7  = f7;
         dec.rd      = inst[7 +: RA_W];
         dec.illegal = !((f7 == F7_ZERO) ||
                         ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end else if (opc == OPC_OP_IMM) begin
         dec.op1      = src1;
         dec.funct3   = f3;
         dec.imm_type = 1'b1;
         dec.rd       = inst[7 +: RA_W];
         if ((f3 == 3'b001) || (f3 == 3'b101)) begin
            // shifts: shamt in the low bits, funct7 passed through
            dec.funct7    = f7;
            dec.immediate = {7'b0, inst[24:20]};
            if (f3 == 3'b001) dec.illegal = (f7 != F7_ZERO);
            else              dec.illegal = !((f7 == F7_ZERO) || (f7 == F7_ALT));
         end else begin
            dec.immediate = inst[31:20];
         end
      end else begin
         dec.illegal = 1'b1;
      end
   end

   assign out_v  = (state_q != EMPTY);
   assign accept = inst_valid & ready_q;
   assign xfer   = out_v & alu_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               load_out = 1'b1;
               state_d  = ONE;
            end
         end
         ONE: begin
            if (accept && xfer) begin
               load_out = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (xfer) begin
               skid_to_out = 1'b1;
               state_d     = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // ready tracks the next skid state so it never depends on alu_ready
   // combinationally; low during reset, high on the first edge after it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b0;
      else        ready_q <= (state_d != FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out)         out_q <= dec;
         else if (skid_to_out) out_q <= skid_q;
         if (load_skid)        skid_q <= dec;
      end
   end

   assign inst_ready = ready_q;
   assign alu_valid  = out_v;
   assign op1        = out_q.op1;
   assign op2        = out_q.op2;
   assign funct3     = out_q.funct3;
   assign funct7     = out_q.funct7;
   assign imm_type   = out_q.imm_type;
   assign immediate  = out_q.immediate;
   assign rd         = out_q.rd;
   assign illegal    = out_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (xfer)                 issue_cnt <= issue_cnt + 32'd1;
         if (out_v && !alu_ready)  stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
